// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clk cycles.
// Define FREQ_METER_FILTER_EN to reject 1-cycle glitches (adds one cycle of latency and settle).
module freq_meter #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned GATE_CYCLES = CLK_FREQ,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             ovf,
  output logic             meas_valid,
  output logic             busy
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
`ifdef FREQ_METER_FILTER_EN
  localparam logic [1:0] SettleLast = 2'd2;
`else
  localparam logic [1:0] SettleLast = 2'd1;
`endif

  typedef enum logic [1:0] {StIdle, StSettle, StGate} state_e;

  state_e           state;
  logic [1:0]       settle_cnt;
  logic [GateW-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_inc;
  logic             sat;
  logic             sat_nxt;
  logic             at_max;
  logic             s1, s2, s3;
  logic             rise;

  // Synchronizer and history flop run in every state so the chain is primed before counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef FREQ_METER_FILTER_EN
  logic f;
  logic f_q;

  // Filtered level follows s2 only after two matching samples.
  assign f    = (s2 == s3) ? s2 : f_q;
  assign rise = f & ~f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f;
    end
  end
`else
  assign rise = s2 & ~s3;
`endif

  assign at_max   = &edge_cnt;
  assign edge_inc = (rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign sat_nxt  = sat | (rise & at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        // Abort discards the partial window; freq_out and ovf keep the last result.
        state      <= StIdle;
        busy       <= 1'b0;
        settle_cnt <= '0;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        sat        <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          StIdle: begin
            state      <= StSettle;
            settle_cnt <= '0;
          end
          StSettle: begin
            if (settle_cnt == SettleLast) begin
              state    <= StGate;
              gate_cnt <= '0;
              edge_cnt <= '0;
              sat      <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          StGate: begin
            if (gate_cnt == GateLast) begin
              // Final cycle's edge belongs to this window; next window restarts immediately.
              freq_out   <= edge_inc;
              ovf        <= sat_nxt;
              meas_valid <= 1'b1;
              gate_cnt   <= '0;
              edge_cnt   <= '0;
              sat        <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
              edge_cnt <= edge_inc;
              sat      <= sat_nxt;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: a window/edge-list model predicts each result.
module tb_freq_meter;

  localparam int G = 200;
  localparam int W = 5;
  localparam int MAXC = (1 << W) - 1;
`ifdef FREQ_METER_FILTER_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic [W-1:0] freq_out;
  logic ovf;
  logic meas_valid;
  logic busy;

  freq_meter #(
    .CLK_FREQ   (50000000),
    .GATE_CYCLES(G),
    .CNT_W      (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .freq_out  (freq_out),
    .ovf       (ovf),
    .meas_valid(meas_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           e;
    logic [W-1:0] f;
    logic         o;
  } exp_t;

  exp_t         sb[$];
  bit           rise_at[int];   // edge index at which each detected rise is counted
  int           cyc = 0;
  int           ws = 0;
  bit           active = 1'b0;
  logic         m_busy = 1'b0;
  logic [W-1:0] m_freq = '0;
  logic         m_ovf = 1'b0;
  int           total = 0;
  int           bad = 0;
  bit           done = 1'b0;

  int   p_hi, p_lo, w_hi, w_lo, w_ph;
  logic man_sig;

  function automatic int count_rises(int s);
    int n = 0;
    for (int k = s; k < s + G; k++) if (rise_at.exists(k)) n++;
    return n;
  endfunction

  function automatic exp_t mk_exp(int e, int n);
    exp_t r;
    r.e = e;
    r.f = (n > MAXC) ? W'(MAXC) : W'(n);
    r.o = (n > MAXC);
    return r;
  endfunction

  // Reference model: window boundaries from en/rst history, counts from the rise list.
  initial begin : model
    exp_t x;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        active = 1'b0;
        m_busy = 1'b0;
        m_freq = '0;
        m_ovf  = 1'b0;
      end else if (!en) begin
        active = 1'b0;
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b1;
        if (!active) begin
          active = 1'b1;
          ws = cyc + 3 + F;
        end else if (cyc == ws + G - 1) begin
          x = mk_exp(cyc, count_rises(ws));
          sb.push_back(x);
          m_freq = x.f;
          m_ovf  = x.o;
          ws += G;
        end
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].e < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid: got no pulse, want one at edge %0d (now %0d)", sb[0].e,
                 cyc);
        x = sb.pop_front();
      end
      total++;
      if (busy !== m_busy) begin
        bad++;
        $display("FAIL busy at edge %0d: got %b want %b", cyc, busy, m_busy);
      end
      total++;
      if (freq_out !== m_freq || ovf !== m_ovf) begin
        bad++;
        $display("FAIL held_result at edge %0d: got %0d/%b want %0d/%b", cyc, freq_out, ovf,
                 m_freq, m_ovf);
      end
      if (meas_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid at edge %0d: got freq %0d, required no pulse", cyc,
                   freq_out);
        end else begin
          x = sb.pop_front();
          if (x.e != cyc || freq_out !== x.f || ovf !== x.o) begin
            bad++;
            $display("FAIL result: got edge %0d freq %0d ovf %b, want edge %0d freq %0d ovf %b",
                     cyc, freq_out, ovf, x.e, x.f, x.o);
          end
        end
      end else if (meas_valid !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL meas_valid_unknown at edge %0d: got %b want 0/1", cyc, meas_valid);
      end
      if (done) begin
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL leftover_results: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Drives sig_in for the coming edge, records its rise, then waits past that edge.
  task automatic tick();
    logic nsig;
    if (rst) begin
      nsig = 1'b0;
      w_ph = 0;
      w_hi = p_hi;
      w_lo = p_lo;
    end else begin
      if (w_ph == 0) begin
        w_hi = p_hi;
        w_lo = p_lo;
      end
      if (w_hi == 0) begin
        nsig = man_sig;
      end else begin
        nsig = (w_ph >= w_lo);
        w_ph = (w_ph + 1) % (w_hi + w_lo);
      end
    end
    if (nsig && !sig_in && (F == 0 || w_hi != 1)) rise_at[cyc + 3 + F] = 1'b1;
    sig_in = nsig;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic run_to_gate_pos(int p);
    int n = 0;
    while (!(active && cyc + 1 - ws == p) && n < 4 * G) begin
      tick();
      n++;
    end
  endtask

  initial begin : stim
    int t;
    p_hi = 5;
    p_lo = 5;
    w_hi = 5;
    w_lo = 5;
    w_ph = 0;
    man_sig = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    run(5);
    rst = 1'b0;
    run(10);
    en = 1'b1;
    run(5 * G + 10);
    p_hi = 2;
    p_lo = 2;
    run(3 * G);
    p_hi = 20;
    p_lo = 20;
    run(3 * G);
    p_hi = 5;
    p_lo = 5;
    run(G);
    run_to_gate_pos(100);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(3 * G + 10);
    run_to_gate_pos(60);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(3 * G + 10);
    p_hi = 1;
    p_lo = 19;
    run(4 * G);
    for (int i = 0; i < 10; i++) begin
      p_hi = $urandom_range(2, 12);
      p_lo = $urandom_range(2, 12);
      run($urandom_range(100, 600));
      case ($urandom_range(0, 3))
        0: begin
          en = 1'b0;
          run($urandom_range(1, 5));
          en = 1'b1;
        end
        1: begin
          rst = 1'b1;
          run($urandom_range(1, 3));
          rst = 1'b0;
        end
        default: ;
      endcase
    end
    // Place one rise so it is counted on the very last cycle of a window.
    p_hi = 0;
    man_sig = 1'b0;
    run(40);
    t = ws + G - 3 - F;
    while (t < cyc + 4) t += G;
    run(t - (cyc + 1));
    man_sig = 1'b1;
    run(4);
    man_sig = 1'b0;
    run(2 * G + 10);
    en = 1'b0;
    run(10);
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL summary_not_reached: got no summary, want one");
    $fatal(1);
  end

endmodule
